// File: rtl/key_event_tracker.sv
// PS/2 frame tracker: detects frame boundaries on the raw PS/2 clock, decodes make/break
// of six game keys into held flags, edge pulses and paddle direction. `KEY_TYPEMATIC_EN adds key_repeat.
module key_event_tracker #(
  parameter int IDLE_CYCLES = 8192,
  parameter int MIN_EDGES   = 11
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       ps_clk_in,
  input  logic [7:0] keyCode,
  input  logic [7:0] sR2data,
  output logic [5:0] held,
  output logic       key_press,
  output logic       key_release,
  output logic [7:0] event_code,
  output logic [1:0] paddle_dir,
  output logic       launch,
  output logic       frame_err,
  output logic       key_repeat
);
  localparam int IW = $clog2(IDLE_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, RECV, DECODE} state_t;

  state_t          state_q, state_d;
  logic [1:0]      sync_q, sync_d;
  logic [4:0]      edge_cnt_q, edge_cnt_d;
  logic [IW-1:0]   idle_cnt_q, idle_cnt_d;
  logic [5:0]      held_q, held_d;
  logic [7:0]      event_q, event_d;
  logic [1:0]      paddle_q, paddle_d;
  logic            press_q, press_d, rel_q, rel_d, launch_q, launch_d, ferr_q, ferr_d;
  logic            rep_q, rep_d;
  logic            fall, trk, left, right;
  logic [2:0]      idx;

  // {tracked, held bit index}; E0-prefixed codes map onto the same bits
  function automatic logic [3:0] key_map(input logic [7:0] c);
    case (c)
      8'h1C:   key_map = 4'b1_000;
      8'h23:   key_map = 4'b1_001;
      8'h6B:   key_map = 4'b1_010;
      8'h74:   key_map = 4'b1_011;
      8'h29:   key_map = 4'b1_100;
      8'h5A:   key_map = 4'b1_101;
      default: key_map = 4'b0_000;
    endcase
  endfunction

  assign sync_d = {sync_q[0], ps_clk_in};
  assign fall   = sync_q[1] & ~sync_q[0];
  assign {trk, idx} = key_map(keyCode);

  always_comb begin
    state_d    = state_q;
    edge_cnt_d = edge_cnt_q;
    idle_cnt_d = idle_cnt_q;
    held_d     = held_q;
    event_d    = event_q;
    press_d    = 1'b0;
    rel_d      = 1'b0;
    launch_d   = 1'b0;
    ferr_d     = 1'b0;
    rep_d      = 1'b0;
    case (state_q)
      IDLE: if (fall) begin
        state_d    = RECV;
        edge_cnt_d = 5'd1;
        idle_cnt_d = '0;
      end
      RECV: begin
        if (fall && edge_cnt_q != 5'd31) edge_cnt_d = edge_cnt_q + 5'd1;
        if (fall || !sync_q[0]) begin
          idle_cnt_d = '0;
        end else if (idle_cnt_q == IW'(IDLE_CYCLES - 1)) begin
          if (int'(edge_cnt_q) < MIN_EDGES) begin
            state_d    = IDLE;
            ferr_d     = 1'b1;
            edge_cnt_d = '0;
            idle_cnt_d = '0;
          end else begin
            state_d = DECODE;
          end
        end else begin
          idle_cnt_d = idle_cnt_q + IW'(1);
        end
      end
      DECODE: begin
        state_d    = IDLE;
        edge_cnt_d = '0;
        idle_cnt_d = '0;
        if (sR2data == 8'hF0 && trk) begin
          if (held_q[idx]) begin
            held_d[idx] = 1'b0;
            rel_d       = 1'b1;
            event_d     = keyCode;
          end
        end else if (keyCode != 8'hF0 && keyCode != 8'hE0 && trk) begin
          if (!held_q[idx]) begin
            held_d[idx] = 1'b1;
            press_d     = 1'b1;
            launch_d    = (keyCode == 8'h29);
            event_d     = keyCode;
          end else begin
`ifdef KEY_TYPEMATIC_EN
            rep_d   = 1'b1;
            event_d = keyCode;
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Paddle follows the new held value so both update in the same cycle
  assign left  = held_d[0] | held_d[2];
  assign right = held_d[1] | held_d[3];
  assign paddle_d = (left == right) ? 2'b00 : (left ? 2'b01 : 2'b10);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= IDLE;
      sync_q     <= 2'b11;
      edge_cnt_q <= '0;
      idle_cnt_q <= '0;
      held_q     <= '0;
      event_q    <= '0;
      paddle_q   <= '0;
      press_q    <= 1'b0;
      rel_q      <= 1'b0;
      launch_q   <= 1'b0;
      ferr_q     <= 1'b0;
      rep_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      edge_cnt_q <= edge_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      held_q     <= held_d;
      event_q    <= event_d;
      paddle_q   <= paddle_d;
      press_q    <= press_d;
      rel_q      <= rel_d;
      launch_q   <= launch_d;
      ferr_q     <= ferr_d;
      rep_q      <= rep_d;
    end
  end

  assign held        = held_q;
  assign key_press   = press_q;
  assign key_release = rel_q;
  assign event_code  = event_q;
  assign paddle_dir  = paddle_q;
  assign launch      = launch_q;
  assign frame_err   = ferr_q;
`ifdef KEY_TYPEMATIC_EN
  assign key_repeat  = rep_q;
`else
  assign key_repeat  = 1'b0;
`endif
endmodule

// File: tb/tb_key_event_tracker.sv
// Directed-frame bench for key_event_tracker; pulses are counted per frame and compared
// against hand-computed expectations.
module tb_key_event_tracker;
  localparam int IDLE = 64;
`ifdef KEY_TYPEMATIC_EN
  localparam int EXP_REP = 2;
`else
  localparam int EXP_REP = 0;
`endif

  logic       Clk = 1'b0, Reset = 1'b1, ps_clk_in = 1'b1;
  logic [7:0] keyCode = 8'h00, sR2data = 8'h00;
  logic [5:0] held;
  logic       key_press, key_release, launch, frame_err, key_repeat;
  logic [7:0] event_code;
  logic [1:0] paddle_dir;

  int n_chk = 0, n_bad = 0;
  int c_press = 0, c_rel = 0, c_launch = 0, c_ferr = 0, c_rep = 0;

  key_event_tracker #(.IDLE_CYCLES(IDLE), .MIN_EDGES(11)) dut (
    .Clk(Clk), .Reset(Reset), .ps_clk_in(ps_clk_in), .keyCode(keyCode), .sR2data(sR2data),
    .held(held), .key_press(key_press), .key_release(key_release), .event_code(event_code),
    .paddle_dir(paddle_dir), .launch(launch), .frame_err(frame_err), .key_repeat(key_repeat)
  );

  always #5 Clk = ~Clk;

  always @(negedge Clk) begin
    c_press  <= c_press  + int'(key_press);
    c_rel    <= c_rel    + int'(key_release);
    c_launch <= c_launch + int'(launch);
    c_ferr   <= c_ferr   + int'(frame_err);
    c_rep    <= c_rep    + int'(key_repeat);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic clr_cnt();
    @(posedge Clk);
    c_press = 0; c_rel = 0; c_launch = 0; c_ferr = 0; c_rep = 0;
  endtask

  task automatic edges(input int n);
    for (int i = 0; i < n; i++) begin
      ps_clk_in = 1'b0;
      repeat (4) @(posedge Clk);
      ps_clk_in = 1'b1;
      repeat (4) @(posedge Clk);
    end
  endtask

  task automatic frame(input logic [7:0] prev, input logic [7:0] code, input int n);
    clr_cnt();
    sR2data = prev;
    keyCode = code;
    edges(n);
    repeat (IDLE + 20) @(posedge Clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_held", 32'(held), 0);
    chk("rst_paddle", 32'(paddle_dir), 0);
    chk("rst_event", 32'(event_code), 0);
    chk("rst_pulses", {27'b0, key_press, key_release, launch, frame_err, key_repeat}, 0);
    Reset = 1'b0;

    frame(8'h00, 8'h1C, 11);
    chk("a_press", c_press, 1);
    chk("a_rel", c_rel, 0);
    chk("a_held", 32'(held), 32'h01);
    chk("a_event", 32'(event_code), 32'h1C);
    chk("a_paddle", 32'(paddle_dir), 32'h1);

    frame(8'h1C, 8'hF0, 11);
    chk("f0_noevt", c_press + c_rel, 0);
    chk("f0_held", 32'(held), 32'h01);
    frame(8'hF0, 8'h1C, 11);
    chk("a_rel_pulse", c_rel, 1);
    chk("a_rel_held", 32'(held), 32'h00);
    chk("a_rel_paddle", 32'(paddle_dir), 32'h0);
    frame(8'hF0, 8'h1C, 11);
    chk("rel_unheld", c_rel, 0);

    frame(8'h1C, 8'hE0, 11);
    frame(8'hE0, 8'h74, 11);
    chk("rt_held", 32'(held), 32'h08);
    chk("rt_paddle", 32'(paddle_dir), 32'h2);
    frame(8'h74, 8'h6B, 11);
    chk("lr_held", 32'(held), 32'h0C);
    chk("lr_paddle", 32'(paddle_dir), 32'h0);
    frame(8'h6B, 8'hE0, 11);
    frame(8'hE0, 8'hF0, 11);
    frame(8'hF0, 8'h6B, 11);
    chk("lrel_held", 32'(held), 32'h08);
    chk("lrel_paddle", 32'(paddle_dir), 32'h2);
    chk("lrel_event", 32'(event_code), 32'h6B);
    frame(8'hF0, 8'h74, 11);
    chk("rrel_held", 32'(held), 32'h00);

    clr_cnt();
    sR2data = 8'h00; keyCode = 8'h29;
    for (int f = 0; f < 3; f++) begin
      edges(11);
      repeat (IDLE + 20) @(posedge Clk);
    end
    #1;
    chk("sp_press", c_press, 1);
    chk("sp_launch", c_launch, 1);
    chk("sp_repeat", c_rep, EXP_REP);
    chk("sp_held", 32'(held), 32'h10);
    chk("sp_event", 32'(event_code), 32'h29);

    frame(8'h00, 8'h1C, 5);
    chk("short_ferr", c_ferr, 1);
    chk("short_held", 32'(held), 32'h10);
    chk("short_press", c_press, 0);

    clr_cnt();
    keyCode = 8'h23;
    edges(6);
    Reset = 1'b1;
    repeat (3) @(posedge Clk);
    Reset = 1'b0;
    repeat (IDLE + 20) @(posedge Clk);
    #1;
    chk("rstmid_ferr", c_ferr, 0);
    chk("rstmid_held", 32'(held), 32'h00);
    chk("rstmid_press", c_press, 0);

    frame(8'h00, 8'h5A, 11);
    chk("ent_held", 32'(held), 32'h20);
    chk("ent_event", 32'(event_code), 32'h5A);
    frame(8'h00, 8'h23, 11);
    chk("d_paddle", 32'(paddle_dir), 32'h2);
    frame(8'h00, 8'h15, 11);
    chk("untrk_pulses", c_press + c_rel + c_launch + c_ferr + c_rep, 0);
    chk("untrk_held", 32'(held), 32'h22);
    chk("untrk_event", 32'(event_code), 32'h23);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/key_event_tracker.md
KEY_EVENT_TRACKER -- requirements
Module: key_event_tracker

Interface
REQ-001 Parameter IDLE_CYCLES, default 8192, meaning Clk cycles of continuous ps_clk_in high that close a frame.
REQ-002 Parameter MIN_EDGES, default 11, meaning minimum ps_clk_in falling edges for a frame to be valid.
REQ-003 Clk  input  1  system clock; all logic on rising edge.
REQ-004 Reset  input  1  asynchronous, active-high reset.
REQ-005 ps_clk_in  input  1  raw PS/2 clock, same pin as the scan-register front end.
REQ-006 keyCode  input  8  newest scan byte from the keyboard front end.
REQ-007 sR2data  input  8  previous scan byte from the keyboard front end.
REQ-008 held  output  6  held flags: [0] A(1C), [1] D(23), [2] left arrow(6B), [3] right arrow(74), [4] space(29), [5] Enter(5A).
REQ-009 key_press  output  1  one-cycle pulse, tracked key went not-held to held.
REQ-010 key_release  output  1  one-cycle pulse, tracked key went held to not-held.
REQ-011 event_code  output  8  scan code of last press/release/repeat event.
REQ-012 paddle_dir  output  2  00 stop, 01 left, 10 right.
REQ-013 launch  output  1  one-cycle pulse on space press.
REQ-014 frame_err  output  1  one-cycle pulse on discarded short frame.
REQ-015 key_repeat  output  1  one-cycle pulse on make of an already-held key (see Configuration).

Function
REQ-016 ps_clk_in SHALL pass a 2-flop synchronizer; falling edge = sync[1] high and sync[0] low.
REQ-017 FSM states: IDLE, RECV, DECODE; IDLE->RECV on first falling edge.
REQ-018 RECV: edge counter increments per falling edge, saturates at 31; idle counter clears on any falling edge or ps_clk low, else increments.
REQ-019 RECV->DECODE when idle counter reaches IDLE_CYCLES-1 with ps_clk high; frames with under MIN_EDGES edges go RECV->IDLE instead and pulse frame_err next cycle.
REQ-020 DECODE lasts exactly one cycle, samples keyCode/sR2data, clears both counters, returns to IDLE.
REQ-021 Decode: sR2data==F0 and keyCode tracked -> release; else keyCode not F0/E0 and tracked -> make; all else -> no event.
REQ-022 Make of non-held key: set held bit, pulse key_press; make of held key: held unchanged, no key_press.
REQ-023 Release of held key: clear bit, pulse key_release; release of non-held key: no pulse.
REQ-024 E0 prefix SHALL be ignored; E0 6B and 6B both map to held[2].
REQ-025 Event pulses, event_code update and held update SHALL appear in the cycle after DECODE (one-cycle latency).
REQ-026 paddle_dir SHALL be registered from held: left=held[0]|held[2], right=held[1]|held[3]; both or neither -> 00.
REQ-027 launch pulses together with key_press when event_code is 29.
REQ-028 At most one event per frame; untracked codes leave every output unchanged except pulses low.

Reset
REQ-029 Reset asserted SHALL force IDLE, clear counters and synchronizer to 1, held=0, paddle_dir=00, event_code=00, all pulses 0.
REQ-030 Reset mid-frame SHALL discard the partial frame; no frame_err after release.

Configuration
REQ-031 Macro KEY_TYPEMATIC_EN defined: make of held key pulses key_repeat and updates event_code; space repeat SHALL NOT pulse launch.
REQ-032 KEY_TYPEMATIC_EN undefined: key_repeat tied 0, repeated makes produce no outputs.

Verification
REQ-033 Frame 1C (11 edges), 8192 idle -> held=000001, key_press 1 cycle, event_code=1C, paddle_dir=01.
REQ-034 Frames F0 then 1C after 1C held -> key_release 1 cycle, held=000000, paddle_dir=00.
REQ-035 E0 74 then 6B make -> held=001100, paddle_dir=00; release E0 F0 6B -> paddle_dir=10.
REQ-036 Three 29 frames -> one key_press, one launch; key_repeat 2 pulses with KEY_TYPEMATIC_EN, 0 without.
REQ-037 5 edges then idle -> frame_err 1 cycle, held unchanged; Reset after 6 edges -> no frame_err, held=0.
REQ-038 Frame 15 (untracked) -> no pulses, held and event_code unchanged.
